// File: rtl/cluster_pkg.sv
// Shared constants, state encoding and word-validity helper for the cluster
// frame scheduler and its compaction stage.
//   No ports.
package cluster_pkg;

    localparam int MXCLSTBITS     = 14;
    localparam int MXADRBITS      = 11;
    localparam int MXCLUSTERS     = 8;
    localparam int MXPADS         = 1536;
    localparam int FIFO_DEPTH     = 32;
    localparam int CLST_PER_FRAME = 4;
    localparam int OVF_BITS       = 16;
    localparam int MXOUTBITS      = CLST_PER_FRAME * MXCLSTBITS;
    localparam int PTR_BITS       = $clog2(FIFO_DEPTH);
    localparam int LVL_BITS       = PTR_BITS + 1;

    localparam logic [MXCLSTBITS-1:0] FILLER = {3'd0, 11'h7FF};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Any address at or above MXPADS is a marker word (filler, not-ready, ...).
    function automatic logic cluster_is_valid(input logic [MXCLSTBITS-1:0] word);
        return word[MXADRBITS-1:0] < MXADRBITS'(MXPADS);
    endfunction

endpackage

// File: rtl/cluster_compact8.sv
// Combinational compaction of one BX worth of packer words: valid words are
// moved to the low slots in their original index order, the remaining slots
// are FILLER.
//   words_in  : MXCLUSTERS packer words, word0 in the low bits
//   words_out : compacted words, first valid word in the low bits
//   count     : number of valid words (0..MXCLUSTERS)
module cluster_compact8
    import cluster_pkg::*;
(
    input  logic [MXCLUSTERS*MXCLSTBITS-1:0] words_in,
    output logic [MXCLUSTERS*MXCLSTBITS-1:0] words_out,
    output logic [3:0]                       count
);

    logic [MXCLSTBITS-1:0] slot [MXCLUSTERS];

    always_comb begin
        for (int i = 0; i < MXCLUSTERS; i++) begin
            slot[i] = FILLER;
        end
        count = 4'd0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            if (cluster_is_valid(words_in[i*MXCLSTBITS +: MXCLSTBITS])) begin
                // count is at most 7 here, so the low 3 bits address the slot
                slot[count[2:0]] = words_in[i*MXCLSTBITS +: MXCLSTBITS];
                count = count + 4'd1;
            end
        end
    end

    always_comb begin
        words_out = '0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            words_out[i*MXCLSTBITS +: MXCLSTBITS] = slot[i];
        end
    end

endmodule

// File: rtl/cluster_frame_scheduler.sv
// Sequences the packer control bits on BX boundaries, compacts the packer's
// cluster words into a multi-write FIFO and drains it as 4-cluster frames
// over a valid/ready link.
//   clock4x, global_reset_n      : 160 MHz clock, synchronous active-low reset
//   enable, bx0                  : run request, BX-boundary strobe
//   alt_priority_en, truncate_cfg: packer control requests
//   reverse_priority_order,
//   truncate_clusters            : packer control outputs
//   clusters_in, clusters_valid  : 8 packer words per BX and their qualifier
//   frame_data/nclst/valid/ready : output frame link
//   fifo_level, overflow_cnt     : occupancy and saturating drop counter
//   busy                         : scheduler not idle
//
// state | meaning
// IDLE  | no ingest, waiting for enable on a BX boundary
// RUN   | ingest packer words and drain frames
// FLUSH | no ingest, drain until FIFO and frame register are empty
module cluster_frame_scheduler
    import cluster_pkg::*;
(
    input  logic                             clock4x,
    input  logic                             global_reset_n,
    input  logic                             enable,
    input  logic                             bx0,
    input  logic                             alt_priority_en,
    input  logic                             truncate_cfg,
    output logic                             reverse_priority_order,
    output logic                             truncate_clusters,
    input  logic [MXCLUSTERS*MXCLSTBITS-1:0] clusters_in,
    input  logic                             clusters_valid,
    output logic [MXOUTBITS-1:0]             frame_data,
    output logic [2:0]                       frame_nclst,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic [LVL_BITS-1:0]              fifo_level,
    output logic [OVF_BITS-1:0]              overflow_cnt,
    output logic                             busy
);

    state_t state, state_next;

    logic [MXCLUSTERS*MXCLSTBITS-1:0] compacted;
    logic [3:0]                       n_valid;

    logic [MXCLSTBITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;

    logic [LVL_BITS-1:0] free_cnt;
    logic [3:0]          n_in;
    logic [3:0]          n_wr;
    logic [3:0]          n_drop;
    logic                pop;
    logic [2:0]          k;
    logic [OVF_BITS:0]   ovf_sum;

    cluster_compact8 u_compact (
        .words_in  (clusters_in),
        .words_out (compacted),
        .count     (n_valid)
    );

    always_comb begin
        n_in     = (state == RUN && clusters_valid) ? n_valid : 4'd0;
        // Space is judged on the pre-cycle level; a same-cycle pop is not credited.
        free_cnt = LVL_BITS'(FIFO_DEPTH) - fifo_level;
        n_wr     = ({2'b00, n_in} > free_cnt) ? free_cnt[3:0] : n_in;
        n_drop   = n_in - n_wr;
        pop      = (fifo_level != '0) && (!frame_valid || frame_ready);
        if (!pop) begin
            k = 3'd0;
        end else if (fifo_level >= LVL_BITS'(CLST_PER_FRAME)) begin
            k = 3'(CLST_PER_FRAME);
        end else begin
            k = fifo_level[2:0];
        end
        ovf_sum = {1'b0, overflow_cnt} + (OVF_BITS+1)'(n_drop);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && bx0) state_next = RUN;
            RUN:     if (!enable) state_next = FLUSH;
            FLUSH:   if (fifo_level == '0 && !frame_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Storage needs no reset: the pointers and level define what is live.
    // Written slots are always free ones, so they never alias the pop window.
    always_ff @(posedge clock4x) begin
        for (int i = 0; i < MXCLUSTERS; i++) begin
            if (i < int'(n_wr)) begin
                fifo_mem[wr_ptr + PTR_BITS'(i)] <= compacted[i*MXCLSTBITS +: MXCLSTBITS];
            end
        end
    end

    always_ff @(posedge clock4x) begin
        if (!global_reset_n) begin
            state                  <= IDLE;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            fifo_level             <= '0;
            overflow_cnt           <= '0;
            frame_valid            <= 1'b0;
            frame_nclst            <= 3'd0;
            frame_data             <= {CLST_PER_FRAME{FILLER}};
            reverse_priority_order <= 1'b0;
            truncate_clusters      <= 1'b0;
        end else begin
            state        <= state_next;
            wr_ptr       <= wr_ptr + PTR_BITS'(n_wr);
            rd_ptr       <= rd_ptr + PTR_BITS'(k);
            fifo_level   <= fifo_level - LVL_BITS'(k) + LVL_BITS'(n_wr);
            overflow_cnt <= ovf_sum[OVF_BITS] ? '1 : ovf_sum[OVF_BITS-1:0];

            if (pop) begin
                for (int j = 0; j < CLST_PER_FRAME; j++) begin
                    frame_data[j*MXCLSTBITS +: MXCLSTBITS] <=
                        (j < int'(k)) ? fifo_mem[rd_ptr + PTR_BITS'(j)] : FILLER;
                end
                frame_nclst <= k;
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (bx0) begin
                truncate_clusters <= truncate_cfg;
            end

            // Cleared as the FSM leaves RUN, so the packer sees normal order in FLUSH.
            if (!alt_priority_en || state_next != RUN) begin
                reverse_priority_order <= 1'b0;
            end else if (state == RUN && bx0) begin
                reverse_priority_order <= ~reverse_priority_order;
            end
        end
    end

endmodule
